fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage pipelined MIPS core.
- Holds the PC and addresses the Harvard instruction memory.
- Selects the next PC from sequential, branch or jump sources, and registers the fetched instruction into decode.
- Obeys StallF/StallD from the hazard unit and kills the wrong-path instruction on taken branches and jumps; carries saturating stall/flush event counters for performance debug.

---
 rtl/fetch_if.sv | 29 ++
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard controls, decode redirect inputs, instruction-memory port and IF/ID outputs.
// The master modport is the fetch stage; the slave modport is the surrounding pipeline and memory.
interface fetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  StallF;
  logic                  StallD;
  logic                  PCSrcD;
  logic                  JumpD;
  logic [DATA_WIDTH-1:0] PCBranchD;
  logic [DATA_WIDTH-1:0] InstrF;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] InstrD;
  logic [DATA_WIDTH-1:0] PCPlus4D;
  logic                  ValidD;
  logic [CNT_WIDTH-1:0]  StallCnt;
  logic [CNT_WIDTH-1:0]  FlushCnt;

  modport master (
    input  StallF, StallD, PCSrcD, JumpD, PCBranchD, InstrF,
    output PCF, InstrD, PCPlus4D, ValidD, StallCnt, FlushCnt
  );

  modport slave (
    output StallF, StallD, PCSrcD, JumpD, PCBranchD, InstrF,
    input  PCF, InstrD, PCPlus4D, ValidD, StallCnt, FlushCnt
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, IF/ID pipeline register
// and saturating stall/flush event counters.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_d_q, instr_d_d;
  logic [DATA_WIDTH-1:0] pcplus4_d_q, pcplus4_d_d;
  logic                  valid_d_q, valid_d_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  logic [DATA_WIDTH-1:0] pcplus4_f;
  logic [DATA_WIDTH-1:0] pc_jump_d;
  logic                  flush_d;

  assign pcplus4_f = pc_q + DATA_WIDTH'(4);
  assign pc_jump_d = {pcplus4_d_q[DATA_WIDTH-1 -: 4], instr_d_q[25:0], 2'b00};
  // A stalled decode keeps its instruction, so the wrong-path slot must survive too.
  assign flush_d   = (bus.PCSrcD | bus.JumpD) & ~bus.StallD;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pc_d = pc_q;
    if (!bus.StallF) begin
      if (bus.JumpD)       pc_d = pc_jump_d;
      else if (bus.PCSrcD) pc_d = bus.PCBranchD;
      else                 pc_d = pcplus4_f;
    end
  end

  always_comb begin
    instr_d_d   = instr_d_q;
    pcplus4_d_d = pcplus4_d_q;
    valid_d_d   = valid_d_q;
    if (!bus.StallD) begin
      if (flush_d) begin
        instr_d_d   = '0;
        pcplus4_d_d = '0;
        valid_d_d   = 1'b0;
      end else begin
        instr_d_d   = bus.InstrF;
        pcplus4_d_d = pcplus4_f;
        valid_d_d   = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_d && (flush_cnt_q != '1))    flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      instr_d_q   <= '0;
      pcplus4_d_q <= '0;
      valid_d_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pc_q        <= pc_d;
      instr_d_q   <= instr_d_d;
      pcplus4_d_q <= pcplus4_d_d;
      valid_d_q   <= valid_d_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PCF      = pc_q;
  assign bus.InstrD   = instr_d_q;
  assign bus.PCPlus4D = pcplus4_d_q;
  assign bus.ValidD   = valid_d_q;
  assign bus.StallCnt = stall_cnt_q;
  assign bus.FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle vectors followed by hand-written
// sequences for asynchronous reset mid-stall and counter saturation on a narrow-counter copy.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();
  fetch_if #(.DATA_WIDTH(32), .CNT_WIDTH(3))  sbus ();

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .CNT_WIDTH(3)) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  // Instruction memory model: address-tagged words, with a j placed at 0x8000_000C.
  function automatic logic [31:0] imem(input logic [31:0] pc);
    if (pc == 32'h8000_000C) return 32'h0800_0040;
    return {8'hE1, pc[23:0]};
  endfunction

  assign bus.InstrF     = imem(bus.PCF);
  assign sbus.InstrF    = imem(sbus.PCF);
  assign sbus.StallF    = bus.StallF;
  assign sbus.StallD    = bus.StallD;
  assign sbus.PCSrcD    = bus.PCSrcD;
  assign sbus.JumpD     = bus.JumpD;
  assign sbus.PCBranchD = bus.PCBranchD;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic sf, input logic sd, input logic ps, input logic j,
                      input logic [31:0] br);
    bus.StallF    = sf;
    bus.StallD    = sd;
    bus.PCSrcD    = ps;
    bus.JumpD     = j;
    bus.PCBranchD = br;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [31:0] pcf, input logic [31:0] instr,
                           input logic [31:0] p4, input logic valid,
                           input logic [31:0] sc, input logic [31:0] fc);
    check({tag, "_pcf"},    bus.PCF,               pcf);
    check({tag, "_instrd"}, bus.InstrD,            instr);
    check({tag, "_pc4d"},   bus.PCPlus4D,          p4);
    check({tag, "_validd"}, {31'd0, bus.ValidD},   {31'd0, valid});
    check({tag, "_stallc"}, {16'd0, bus.StallCnt}, sc);
    check({tag, "_flushc"}, {16'd0, bus.FlushCnt}, fc);
  endtask

  typedef struct {
    logic        sf, sd, ps, j;
    logic [31:0] br;
    logic [31:0] pcf, instr, p4;
    logic        valid;
    logic [31:0] sc, fc;
  } vec_t;

  function automatic vec_t mk(input logic sf, input logic sd, input logic ps, input logic j,
                              input logic [31:0] br, input logic [31:0] pcf,
                              input logic [31:0] instr, input logic [31:0] p4,
                              input logic valid, input logic [31:0] sc, input logic [31:0] fc);
    vec_t v;
    v.sf = sf; v.sd = sd; v.ps = ps; v.j = j; v.br = br;
    v.pcf = pcf; v.instr = instr; v.p4 = p4; v.valid = valid; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  localparam int NVEC = 26;
  vec_t tbl [NVEC];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // sequential fetch from reset
    tbl[0]  = mk(0,0,0,0, 32'h0,         32'h4,         imem(32'h0),  32'h4,  1, 0, 0);
    tbl[1]  = mk(0,0,0,0, 32'h0,         32'h8,         imem(32'h4),  32'h8,  1, 0, 0);
    tbl[2]  = mk(0,0,0,0, 32'h0,         32'hC,         imem(32'h8),  32'hC,  1, 0, 0);
    tbl[3]  = mk(0,0,0,0, 32'h0,         32'h10,        imem(32'hC),  32'h10, 1, 0, 0);
    // three-cycle full stall at 0x10
    tbl[4]  = mk(1,1,0,0, 32'h0,         32'h10,        imem(32'hC),  32'h10, 1, 1, 0);
    tbl[5]  = mk(1,1,0,0, 32'h0,         32'h10,        imem(32'hC),  32'h10, 1, 2, 0);
    tbl[6]  = mk(1,1,0,0, 32'h0,         32'h10,        imem(32'hC),  32'h10, 1, 3, 0);
    tbl[7]  = mk(0,0,0,0, 32'h0,         32'h14,        imem(32'h10), 32'h14, 1, 3, 0);
    tbl[8]  = mk(0,0,0,0, 32'h0,         32'h18,        imem(32'h14), 32'h18, 1, 3, 0);
    tbl[9]  = mk(0,0,0,0, 32'h0,         32'h1C,        imem(32'h18), 32'h1C, 1, 3, 0);
    tbl[10] = mk(0,0,0,0, 32'h0,         32'h20,        imem(32'h1C), 32'h20, 1, 3, 0);
    // taken branch at 0x20
    tbl[11] = mk(0,0,1,0, 32'h100,       32'h100,       32'h0,        32'h0,  0, 3, 1);
    tbl[12] = mk(0,0,0,0, 32'h0,         32'h104,       imem(32'h100),32'h104,1, 3, 1);
    // branch onto the j, then jump wins over a simultaneous branch
    tbl[13] = mk(0,0,1,0, 32'h8000_000C, 32'h8000_000C, 32'h0,        32'h0,  0, 3, 2);
    tbl[14] = mk(0,0,0,0, 32'h0,         32'h8000_0010, 32'h0800_0040,32'h8000_0010, 1, 3, 2);
    tbl[15] = mk(0,0,1,1, 32'h200,       32'h8000_0100, 32'h0,        32'h0,  0, 3, 3);
    tbl[16] = mk(0,0,0,0, 32'h0,         32'h8000_0104, 32'hE100_0100,32'h8000_0104, 1, 3, 3);
    // branch held under a full stall, applied on the first unstalled cycle
    tbl[17] = mk(1,1,1,0, 32'h300,       32'h8000_0104, 32'hE100_0100,32'h8000_0104, 1, 4, 3);
    tbl[18] = mk(1,1,1,0, 32'h300,       32'h8000_0104, 32'hE100_0100,32'h8000_0104, 1, 5, 3);
    tbl[19] = mk(0,0,1,0, 32'h300,       32'h300,       32'h0,        32'h0,  0, 5, 4);
    tbl[20] = mk(0,0,0,0, 32'h0,         32'h304,       imem(32'h300),32'h304,1, 5, 4);
    // StallF=0 with StallD=1: PC redirects, IF/ID holds, no flush counted
    tbl[21] = mk(0,1,1,0, 32'h400,       32'h400,       imem(32'h300),32'h304,1, 5, 4);
    tbl[22] = mk(0,0,0,0, 32'h0,         32'h404,       imem(32'h400),32'h404,1, 5, 4);
    // PC+4 wraps from 0xFFFF_FFFC to 0
    tbl[23] = mk(0,0,1,0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,        32'h0,  0, 5, 5);
    tbl[24] = mk(0,0,0,0, 32'h0,         32'h0,         32'hE1FF_FFFC,32'h0,  1, 5, 5);
    tbl[25] = mk(0,0,0,0, 32'h0,         32'h4,         32'hE100_0000,32'h4,  1, 5, 5);

    rst_n         = 1'b0;
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.PCSrcD    = 1'b0;
    bus.JumpD     = 1'b0;
    bus.PCBranchD = '0;
    #12;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].sf, tbl[i].sd, tbl[i].ps, tbl[i].j, tbl[i].br);
      check_all($sformatf("v%0d", i), tbl[i].pcf, tbl[i].instr, tbl[i].p4,
                tbl[i].valid, tbl[i].sc, tbl[i].fc);
    end

    // asynchronous reset between edges while stalled at 0x40
    step(0, 0, 1, 0, 32'h40);
    step(1, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    check_all("prerst", 32'h40, 32'h0, 32'h0, 1'b0, 7, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("asyncrst", 32'h0, 32'h0, 32'h0, 1'b0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check("rsthold_pcf",    bus.PCF,                32'h0);
    check("rsthold_stallc", {16'd0, bus.StallCnt},  32'h0);
    rst_n = 1'b1;

    // saturation: the 3-bit copy must stop at 7 while the 16-bit one keeps counting
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 32'h0);
    check("sat_small_stallc", {29'd0, sbus.StallCnt}, 32'd7);
    check("sat_main_stallc",  {16'd0, bus.StallCnt},  32'd9);
    check("sat_small_flushc", {29'd0, sbus.FlushCnt}, 32'd0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 32'h0);
    check("sat_small_flushc2", {29'd0, sbus.FlushCnt}, 32'd7);
    check("sat_main_flushc",   {16'd0, bus.FlushCnt},  32'd9);
    check("sat_small_stallc2", {29'd0, sbus.StallCnt}, 32'd7);
    check("sat_small_validd",  {31'd0, sbus.ValidD},   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
